bus_master: RTL

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master_pkg.sv | 13 +
 rtl/bus_master_if.sv | 38 +++
 rtl/bus_master.sv | 64 ++++++
 3 files changed

// File: rtl/bus_master_pkg.sv
// bus_master_pkg: shared bus width defaults and FSM state encoding for the burst bus master
package bus_master_pkg;
  localparam int D_DEF = 8;
  localparam int A_BITS_DEF = 16;
  localparam int LEN_BITS_DEF = 8;
  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_STROBE,
    RD_CAPTURE,
    RSP_HOLD
  } state_t;
endpackage

// File: rtl/bus_master_if.sv
// bus_master_if: command, write-data, read-response and decoder bus signals of the burst bus master
interface bus_master_if import bus_master_pkg::*; #(
  parameter int D = D_DEF,
  parameter int A_BITS = A_BITS_DEF,
  parameter int LEN_BITS = LEN_BITS_DEF
);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [A_BITS-1:0] cmd_addr;
  logic [LEN_BITS-1:0] cmd_len;
  logic cmd_incr;
  logic wr_valid;
  logic wr_ready;
  logic [D-1:0] wr_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [D-1:0] rsp_data;
  logic rsp_last;
  logic busy;
  logic [A_BITS-1:0] a;
  logic read_strobe;
  logic write_strobe;
  logic [D-1:0] read_data;
  logic [D-1:0] bus_wdata;
  modport master (
    input cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_incr,
    input wr_valid, wr_data, rsp_ready, read_data,
    output cmd_ready, wr_ready, rsp_valid, rsp_data, rsp_last,
    output busy, a, read_strobe, write_strobe, bus_wdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_incr,
    output wr_valid, wr_data, rsp_ready, read_data,
    input cmd_ready, wr_ready, rsp_valid, rsp_data, rsp_last,
    input busy, a, read_strobe, write_strobe, bus_wdata
  );
endinterface

// File: rtl/bus_master.sv
// bus_master: burst command engine driving single-cycle read/write strobes onto a decoded bus
module bus_master import bus_master_pkg::*; #(
  parameter int D = D_DEF,
  parameter int A_BITS = A_BITS_DEF,
  parameter int LEN_BITS = LEN_BITS_DEF
) (
  input logic clk,
  input logic rst_n,
  bus_master_if.master bus
);
  state_t state, state_nxt;
  logic [A_BITS-1:0] addr;
  logic [LEN_BITS-1:0] cnt;
  logic [D-1:0] rsp_q;
  logic incr;
  logic accept;
  logic xfer_done;
  logic last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    accept = state == IDLE && bus.cmd_valid;
    xfer_done = (state == WR_WAIT && bus.wr_valid) || (state == RSP_HOLD && bus.rsp_ready);
    last = cnt == '0;
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = accept ? (bus.cmd_write ? WR_WAIT : RD_STROBE) : IDLE;
      WR_WAIT:    state_nxt = xfer_done ? (last ? IDLE : WR_WAIT) : WR_WAIT;
      RD_STROBE:  state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = RSP_HOLD;
      RSP_HOLD:   state_nxt = xfer_done ? (last ? IDLE : RD_STROBE) : RSP_HOLD;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      cnt <= '0;
      incr <= 1'b0;
      rsp_q <= '0;
    end else begin
      if (accept) begin
        addr <= bus.cmd_addr;
        cnt <= bus.cmd_len;
        incr <= bus.cmd_incr;
      end else if (xfer_done) begin
        addr <= addr + A_BITS'(incr);
        cnt <= last ? cnt : cnt - LEN_BITS'(1);
      end
      if (state == RD_CAPTURE) rsp_q <= bus.read_data;
    end
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.wr_ready = state == WR_WAIT;
  assign bus.write_strobe = state == WR_WAIT && bus.wr_valid;
  assign bus.bus_wdata = bus.write_strobe ? bus.wr_data : '0;
  assign bus.read_strobe = state == RD_STROBE;
  assign bus.a = addr;
  assign bus.rsp_valid = state == RSP_HOLD;
  assign bus.rsp_last = state == RSP_HOLD && last;
  assign bus.rsp_data = rsp_q;
  strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus.read_strobe && bus.write_strobe));
endmodule
